// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Holds the controller state encoding, default widths, gen_speed encodings
// and the preset ratio table used on reset and on gen_speed changes.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ALIGN = 2'd3
    } state_e;

    localparam int unsigned CNT_W_DEF  = 7;
    localparam int unsigned NUM_CH_DEF = 3;

    localparam logic [1:0] GEN4     = 2'b00;
    localparam logic [1:0] GEN3     = 2'b01;
    localparam logic [1:0] GEN2     = 2'b10;
    localparam logic [1:0] GEN4_ALT = 2'b11;

    // Preset divide ratio for a channel; channels beyond ch2 always run at 2.
    function automatic int unsigned preset_ratio(input logic [1:0] gen, input int unsigned ch);
        int unsigned r;
        r = 2;
        if (ch < 3) begin
            case (gen)
                GEN3:           r = (ch == 2) ? 33 : 4;
                GEN2:           r = (ch == 2) ? 66 : 8;
                GEN4, GEN4_ALT: r = (ch == 2) ? 16 : 2;
                default:        r = 2;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, 50% duty generator (negedge stage
// for odd ratios), end-of-period strobe and park handshake for retiming.
// Ports:
//   local_clk, rst   source clock / async active-low reset
//   ratio            active divide ratio (values <2 behave as 2)
//   cnt_en           controller is in RUN or DRAIN
//   drain            controller is draining: park at end of current period
//   align            controller is aligning: restart at cnt=0 next edge
//   clk_out          divided clock
//   clk_strobe       high on the last source cycle of each period
//   parked           channel has finished its period and is holding
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ratio,
    input  logic             cnt_en,
    input  logic             drain,
    input  logic             align,
    output logic             clk_out,
    output logic             clk_strobe,
    output logic             parked
);

    localparam int unsigned HW = CNT_W + 1;

    logic [CNT_W-1:0] r_eff;
    logic [CNT_W-1:0] rm1;
    logic [HW-1:0]    half;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             park_q, park_d;
    logic             strobe_q, strobe_d;

    // Next counter / phase / park state.
    always_comb begin
        r_eff  = (ratio < CNT_W'(2)) ? CNT_W'(2) : ratio;
        rm1    = r_eff - CNT_W'(1);
        // High while cnt < ceil(r/2): r/2 for even, (r-1)/2 inclusive for odd.
        half   = HW'(({1'b0, r_eff} + HW'(1)) >> 1);
        cnt_d  = cnt_q;
        park_d = park_q;
        pos_d  = 1'b0;
        if (align) begin
            cnt_d  = '0;
            park_d = 1'b0;
            pos_d  = 1'b1;
        end else if (cnt_en) begin
            if (!park_q) begin
                if (cnt_q >= rm1) begin
                    // Period complete: park (count held) when draining, else wrap.
                    if (drain) begin
                        park_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            pos_d = !park_d && ({1'b0, cnt_d} < half);
        end else begin
            cnt_d  = '0;
            park_d = 1'b0;
        end
        neg_d    = pos_q;
        strobe_d = !park_d && (cnt_d == rm1);
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            pos_q    <= 1'b0;
            park_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            park_q   <= park_d;
            strobe_q <= strobe_d;
        end
    end

    // Half-cycle delayed copy; ANDed in for odd ratios to trim the high phase.
    always_ff @(negedge local_clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_out    = r_eff[0] ? (pos_q & neg_q) : pos_q;
    assign clk_strobe = strobe_q;
    assign parked     = park_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider with glitch-free, phase-aligned ratio changes.
// A change (cfg request or gen_speed preset) drains every channel to the end
// of its current period, then restarts all channels together on one edge.
// Ports:
//   local_clk, rst   source clock / async active-low reset
//   gen_speed        preset select (00/11 gen4, 01 gen3, 10 gen2)
//   cfg_valid        request to apply cfg_ratio
//   cfg_ratio        per-channel ratio, ch i at [i*CNT_W +: CNT_W]
//   cfg_ready        request accepted when high together with cfg_valid
//   clk_out          divided clocks
//   clk_strobe       per-channel end-of-period pulse
//   busy             controller is not in RUN
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    local_clk,
    input  logic                    rst,
    input  logic [1:0]              gen_speed,
    input  logic                    cfg_valid,
    input  logic [NUM_CH*CNT_W-1:0] cfg_ratio,
    output logic                    cfg_ready,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       clk_strobe,
    output logic                    busy
);

    localparam int unsigned VEC_W = NUM_CH * CNT_W;

    state_e            state_q, state_d;
    logic [VEC_W-1:0]  pend_q, pend_d;
    logic [VEC_W-1:0]  ratio_q, ratio_d;
    logic [VEC_W-1:0]  preset_c;
    logic [1:0]        gen_q, gen_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] parked;
    logic              cnt_en;
    logic              drain;
    logic              align;

    // Preset ratios for the current gen_speed.
    always_comb begin
        preset_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            preset_c[i*CNT_W +: CNT_W] = CNT_W'(preset_ratio(gen_speed, i));
        end
    end

    // Controller next state; cfg request has priority over a preset change,
    // which stays visible (gen_q unchanged) and is picked up in a later RUN.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ratio_d = ratio_q;
        gen_d   = gen_q;
        case (state_q)
            ST_INIT: begin
                pend_d  = preset_c;
                gen_d   = gen_speed;
                state_d = ST_ALIGN;
            end
            ST_RUN: begin
                if (cfg_valid && ready_q) begin
                    pend_d  = cfg_ratio;
                    state_d = ST_DRAIN;
                end else if (gen_speed != gen_q) begin
                    pend_d  = preset_c;
                    gen_d   = gen_speed;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (&parked) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                ratio_d = pend_q;
                state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
        ready_d = (state_d == ST_RUN);
        busy_d  = !ready_d;
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            pend_q  <= '0;
            ratio_q <= '0;
            gen_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ratio_q <= ratio_d;
            gen_q   <= gen_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign drain  = (state_q == ST_DRAIN);
    assign align  = (state_q == ST_ALIGN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .local_clk (local_clk),
            .rst       (rst),
            .ratio     (ratio_q[g*CNT_W +: CNT_W]),
            .cnt_en    (cnt_en),
            .drain     (drain),
            .align     (align),
            .clk_out   (clk_out[g]),
            .clk_strobe(clk_strobe[g]),
            .parked    (parked[g])
        );
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi. The reference model works on a
// schedule: each restart edge t0 plus per-channel ratios gives the waveform
// by modular arithmetic over half-cycles; an accepted change computes the
// per-channel park cycle and the common restart edge directly.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 7;

    logic                    local_clk;
    logic                    rst;
    logic [1:0]              gen_speed;
    logic                    cfg_valid;
    logic [NUM_CH*CNT_W-1:0] cfg_ratio;
    logic                    cfg_ready;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       clk_strobe;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int       k;
    int       t0;
    int       r_edge;
    int       act_r   [NUM_CH];
    int       pend_r  [NUM_CH];
    int       park_at [NUM_CH];
    bit       in_reset;
    bit       init_pending;
    bit       in_run;
    bit       draining;
    logic [1:0] gen_app;
    int       tbl [4][3] = '{'{2, 2, 16}, '{4, 4, 33}, '{8, 8, 66}, '{2, 2, 16}};

    clk_div_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .gen_speed (gen_speed),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .clk_strobe(clk_strobe),
        .busy      (busy)
    );

    initial local_clk = 1'b0;
    always #5 local_clk = ~local_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, got, exp, $time, k);
        end
    endtask

    function automatic int clamp_r(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    function automatic int preset_of(input logic [1:0] g, input int ch);
        if (ch >= 3) return 2;
        return tbl[g][ch];
    endfunction

    // Level of a divided clock d cycles after restart, in half h of the cycle.
    function automatic bit wave(input int d, input int h, input int r);
        int t;
        t = (2 * d + h) % (2 * r);
        if (r % 2 == 0) return t < r;
        return (t >= 1) && (t <= r);
    endfunction

    function automatic bit ch_live(input int i);
        return !in_reset && (in_run || (draining && k < park_at[i]));
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clk(input int h);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_live(i)) v[i] = wave(k - t0, h, act_r[i]);
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_strobe();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_live(i)) v[i] = ((k - t0) % act_r[i]) == (act_r[i] - 1);
        end
        return v;
    endfunction

    // Model reaction to the inputs seen at posedge number k.
    task automatic model_edge();
        int  mx;
        int  rem;
        bit  accept;
        if (init_pending) begin
            init_pending = 0;
            in_reset     = 0;
            in_run       = 0;
            draining     = 1;
            gen_app      = gen_speed;
            r_edge       = k + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_r[i]  = preset_of(gen_speed, i);
                park_at[i] = k;
            end
        end else if (in_reset) begin
            accept = 0;
        end else if (draining) begin
            if (k == r_edge) begin
                t0       = k;
                draining = 0;
                in_run   = 1;
                for (int i = 0; i < NUM_CH; i++) act_r[i] = pend_r[i];
            end
        end else if (in_run) begin
            accept = 0;
            if (cfg_valid) begin
                accept = 1;
                for (int i = 0; i < NUM_CH; i++)
                    pend_r[i] = clamp_r(int'(cfg_ratio[i*CNT_W +: CNT_W]));
            end else if (gen_speed != gen_app) begin
                accept  = 1;
                gen_app = gen_speed;
                for (int i = 0; i < NUM_CH; i++) pend_r[i] = preset_of(gen_speed, i);
            end
            if (accept) begin
                mx = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    rem        = act_r[i] - ((k - t0) % act_r[i]);
                    park_at[i] = k + rem;
                    if (rem > mx) mx = rem;
                end
                r_edge   = k + mx + 2;
                draining = 1;
                in_run   = 0;
            end
        end
    endtask

    task automatic check_outputs(input int h);
        check_eq(h == 0 ? "clk_out_hi_half" : "clk_out_lo_half", 32'(clk_out), 32'(exp_clk(h)));
        check_eq("clk_strobe", 32'(clk_strobe), 32'(exp_strobe()));
        check_eq("busy", 32'(busy), 32'(!in_run));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(in_run));
    endtask

    task automatic run_cycle();
        @(posedge local_clk);
        k++;
        model_edge();
        #1;
        check_outputs(0);
        @(negedge local_clk);
        #1;
        check_outputs(1);
    endtask

    // Asynchronous reset between edges, held for a few cycles, released with gs.
    task automatic do_reset(input int cycles, input logic [1:0] gs);
        #1;
        rst          = 1'b0;
        in_reset     = 1;
        in_run       = 0;
        draining     = 0;
        init_pending = 0;
        #1;
        check_outputs(1);
        repeat (cycles) run_cycle();
        gen_speed    = gs;
        rst          = 1'b1;
        init_pending = 1;
    endtask

    initial begin
        k            = 0;
        t0           = 0;
        r_edge       = 0;
        in_reset     = 1;
        init_pending = 0;
        in_run       = 0;
        draining     = 0;
        gen_app      = 2'b00;
        for (int i = 0; i < NUM_CH; i++) begin
            act_r[i]   = 2;
            pend_r[i]  = 2;
            park_at[i] = 0;
        end
        rst       = 1'b0;
        gen_speed = 2'b01;
        cfg_valid = 1'b0;
        cfg_ratio = '0;

        // Power-on reset, gen3 preset.
        repeat (3) run_cycle();
        rst          = 1'b1;
        init_pending = 1;
        repeat (80) run_cycle();

        // Explicit ratios 5/3/7.
        cfg_ratio = {7'd7, 7'd3, 7'd5};
        cfg_valid = 1'b1;
        run_cycle();
        cfg_valid = 1'b0;
        repeat (60) run_cycle();

        // Preset changes gen4 then gen2.
        gen_speed = 2'b00;
        repeat (60) run_cycle();
        gen_speed = 2'b10;
        repeat (200) run_cycle();

        // Simultaneous cfg (with ratios 0 and 1) and gen_speed change.
        cfg_ratio = {7'd9, 7'd1, 7'd0};
        cfg_valid = 1'b1;
        gen_speed = 2'b01;
        run_cycle();
        cfg_valid = 1'b0;
        repeat (250) run_cycle();

        // Reset while draining a pending cfg.
        cfg_ratio = {7'd20, 7'd20, 7'd20};
        cfg_valid = 1'b1;
        run_cycle();
        cfg_valid = 1'b0;
        run_cycle();
        do_reset(2, 2'b10);
        repeat (200) run_cycle();

        // Randomized traffic.
        repeat (3000) begin
            cfg_valid = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NUM_CH; i++)
                cfg_ratio[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 24));
            if ($urandom_range(0, 59) == 0) gen_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) do_reset(int'($urandom_range(1, 3)), 2'($urandom_range(0, 3)));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 3: number of divided-clock channels (ch0 = ser, ch1 = fsm, ch2 = enc).
REQ-002 Parameter CNT_W, default 7: ratio/counter width; supports ratios up to 2^CNT_W-1 (66 needs CNT_W>=7).
REQ-003 local_clk  in  1  source clock; both edges used.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 gen_speed  in  2  preset select: 00 gen4, 01 gen3, 10 gen2, 11 = gen4.
REQ-006 cfg_valid  in  1  request to apply cfg_ratio.
REQ-007 cfg_ratio  in  NUM_CH*CNT_W  per-channel divide ratio; ch i occupies bits [i*CNT_W +: CNT_W].
REQ-008 cfg_ready  out  1  high only in RUN; a request is accepted when cfg_valid and cfg_ready are both high.
REQ-009 clk_out  out  NUM_CH  divided clocks, 50% duty.
REQ-010 clk_strobe  out  NUM_CH  one-local_clk-cycle pulse on the last cycle of each period.
REQ-011 busy  out  1  high in INIT, DRAIN and ALIGN.

Function
REQ-012 Ratio rule: a programmed ratio r<2 SHALL be used as 2.
REQ-013 Each channel counter SHALL count 0..r-1 on posedge local_clk and wrap to 0.
REQ-014 Even r: clk_out[i] SHALL be high while cnt<r/2.
REQ-015 Odd r: pos_q SHALL be high for cnt<=(r-1)/2; neg_q SHALL be pos_q captured on negedge; clk_out = pos_q & neg_q, giving r/2 source cycles high.
REQ-016 clk_strobe[i] SHALL be high exactly while cnt==r-1 in RUN or DRAIN, and never while the channel is parked.
REQ-017 FSM states: INIT, RUN, DRAIN, ALIGN.
REQ-018 INIT: first cycle after reset release; SHALL load pending ratios from the preset table for gen_speed, then go to ALIGN.
REQ-019 Preset table (ch0,ch1,ch2): gen4 {2,2,16}, gen3 {4,4,33}, gen2 {8,8,66}; channels >=3 use 2.
REQ-020 RUN: cfg_valid&cfg_ready SHALL latch cfg_ratio as pending and go to DRAIN.
REQ-021 RUN: if gen_speed differs from the last-applied gen_speed and cfg_valid is low, the preset for gen_speed SHALL be latched as pending and the FSM SHALL go to DRAIN.
REQ-022 RUN: cfg_valid SHALL win over a simultaneous gen_speed change; the change SHALL be serviced in a later RUN cycle.
REQ-023 DRAIN: each channel SHALL complete its current period (cnt==r-1), then park with cnt held and clk_out low.
REQ-024 DRAIN: once all channels are parked the FSM SHALL go to ALIGN.
REQ-025 ALIGN: one cycle; pending ratios SHALL become active, all counters SHALL be set to 0, and all clk_out SHALL stay low.
REQ-026 ALIGN is followed by RUN; all channels SHALL start cnt=0 on the same posedge (even channels rise there, odd channels half a cycle later).
REQ-027 Latency: from acceptance to the common restart edge SHALL be (max remaining cycles over channels) + 2 cycles.
REQ-028 cfg_valid and gen_speed changes during DRAIN, ALIGN and INIT SHALL be ignored (cfg_ready=0); a gen_speed change stays pending per REQ-021.
REQ-029 clk_out SHALL never produce a high or low phase shorter than min(active, new) r/2 source cycles (no glitches).

Reset
REQ-030 During rst=0: clk_out=0, clk_strobe=0, cfg_ready=0, busy=1, counters and pos_q/neg_q =0, state=INIT.
REQ-031 Reset asserted mid-DRAIN/ALIGN SHALL discard pending ratios; after release the preset for the current gen_speed SHALL be applied.

Structure
REQ-032 Package clk_div_pkg SHALL hold: the state enum, default CNT_W, the preset-table function (gen_speed, channel -> ratio) and the gen_speed encodings.
REQ-033 One sub-module, clk_div_chan, SHALL implement a single channel (counter, even/odd generator, negedge stage, park, strobe) and be instantiated NUM_CH times by generate.

Verification
REQ-034 Reset release with gen_speed=01 -> busy low after 2 cycles; ch0 period 4, ch2 period 33 with high 16.5 cycles; strobes every 4/4/33 cycles.
REQ-035 In RUN, cfg_ratio={5,3,7} with cfg_valid=1 -> cfg_ready drops; all channels restart on one edge; periods 5/3/7, each 50% duty, no glitch.
REQ-036 gen_speed 00->10 in RUN -> DRAIN, then periods 8/8/66 with aligned restart; latency <= 18 cycles.
REQ-037 cfg_valid and gen_speed change in the same cycle -> cfg_ratio applied first, then the preset is applied in a second DRAIN/ALIGN sequence.
REQ-038 cfg_ratio entries 0 and 1 -> those channels run at ratio 2.
REQ-039 rst asserted mid-DRAIN -> all outputs low at once; after release the gen_speed preset is active and pending cfg is lost.
